// File: rtl/program_loader.sv
// program_loader: receives a byte-stream program image (count, big-endian
// data words, XOR checksum) and writes it into instruction memory while
// holding the CPU core in reset.
module program_loader #(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              chk_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_DATA,
    S_CHECK,
    S_FIN
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] word_cnt;
  logic [ADDR_W-1:0] word_idx;
  logic [ADDR_W-1:0] idx_inc;
  logic [1:0]        byte_pos;
  logic [23:0]       word_buf;
  logic [7:0]        acc;
  logic              xfer;
  logic              last_word;

  assign xfer    = in_valid && in_ready;
  assign idx_inc = word_idx + ADDR_W'(1);
  // A count of zero means a full address space: the index wraps to 0 on the last word.
  assign last_word = (idx_inc == word_cnt);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state: advance only on accepted bytes; FIN always lasts one cycle
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (load_start) state_nxt = S_COUNT;
      S_COUNT: if (xfer) state_nxt = S_DATA;
      S_DATA:  if (xfer && byte_pos == 2'd3 && last_word) state_nxt = S_CHECK;
      S_CHECK: if (xfer) state_nxt = S_FIN;
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    in_ready = (state == S_COUNT) || (state == S_DATA) || (state == S_CHECK);
    busy     = (state != S_IDLE);
    cpu_hold = (state != S_IDLE);
    done     = (state == S_FIN);
  end

  // Datapath: word assembly, memory write port, checksum accumulator
  always_ff @(posedge clk) begin
    if (reset) begin
      word_cnt  <= '0;
      word_idx  <= '0;
      byte_pos  <= '0;
      word_buf  <= '0;
      acc       <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= BASE_ADDR;
      mem_wdata <= '0;
      chk_err   <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (load_start) begin
            acc      <= '0;
            chk_err  <= 1'b0;
            word_idx <= '0;
            byte_pos <= '0;
          end
        end
        S_COUNT: begin
          if (xfer) word_cnt <= ADDR_W'(in_data);
        end
        S_DATA: begin
          if (xfer) begin
            acc      <= acc ^ in_data;
            byte_pos <= byte_pos + 2'd1;
            word_buf <= {word_buf[15:0], in_data};
            if (byte_pos == 2'd3) begin
              mem_we    <= 1'b1;
              mem_addr  <= BASE_ADDR + word_idx;
              mem_wdata <= {word_buf, in_data};
              word_idx  <= idx_inc;
            end
          end
        end
        S_CHECK: begin
          if (xfer) chk_err <= (in_data != acc);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: two instances (base 00 and base FF) share one
// stimulus stream; a transaction-level model predicts every output each cycle.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset, load_start, in_valid;
  logic [7:0]  in_data;
  logic        in_ready, mem_we, cpu_hold, busy, done, chk_err;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        w_in_ready, w_mem_we, w_cpu_hold, w_busy, w_done, w_chk_err;
  logic [7:0]  w_mem_addr;
  logic [31:0] w_mem_wdata;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  program_loader #(.ADDR_W(8), .BASE_ADDR(8'h00)) u_dut (
    .clk(clk), .reset(reset), .load_start(load_start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_hold(cpu_hold), .busy(busy), .done(done),
    .chk_err(chk_err)
  );

  program_loader #(.ADDR_W(8), .BASE_ADDR(8'hFF)) u_wrap (
    .clk(clk), .reset(reset), .load_start(load_start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(w_in_ready), .mem_we(w_mem_we), .mem_addr(w_mem_addr),
    .mem_wdata(w_mem_wdata), .cpu_hold(w_cpu_hold), .busy(w_busy), .done(w_done),
    .chk_err(w_chk_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: counts accepted bytes of the current load
  bit          m_loading, m_fin, m_we, m_chk;
  int          m_n, m_consumed;
  logic [7:0]  m_acc, m_off;
  logic [31:0] m_w, m_wdata;

  always @(posedge clk) begin
    if (reset) begin
      m_loading = 0; m_fin = 0; m_we = 0; m_chk = 0;
      m_acc = '0; m_off = '0; m_wdata = '0; m_w = '0; m_consumed = 0; m_n = 0;
    end else begin
      m_we = 0;
      if (m_fin) begin
        m_fin = 0;
      end else if (m_loading) begin
        if (in_valid) begin
          if (m_consumed == 0) begin
            m_n = (in_data == 8'h00) ? 256 : int'(in_data);
          end else if (m_consumed <= 4 * m_n) begin
            m_acc = m_acc ^ in_data;
            m_w   = {m_w[23:0], in_data};
            if (m_consumed % 4 == 0) begin
              m_we    = 1;
              m_off   = 8'(m_consumed / 4 - 1);
              m_wdata = m_w;
            end
          end else begin
            m_chk     = (in_data != m_acc);
            m_loading = 0;
            m_fin     = 1;
          end
          m_consumed++;
        end
      end else if (load_start) begin
        m_loading = 1; m_consumed = 0; m_acc = '0; m_chk = 0;
      end
    end
  end

  // Observed write log and done-pulse count for literal checks
  logic [7:0]  log_addr[$];
  logic [31:0] log_data[$];
  logic [7:0]  wlog_addr[$];
  int          ndone;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready",  in_ready,  m_loading);
      chk("busy",      busy,      m_loading | m_fin);
      chk("cpu_hold",  cpu_hold,  m_loading | m_fin);
      chk("done",      done,      m_fin);
      chk("chk_err",   chk_err,   m_chk);
      chk("mem_we",    mem_we,    m_we);
      chk("mem_addr",  mem_addr,  8'(8'h00 + m_off));
      chk("mem_wdata", mem_wdata, m_wdata);
      chk("w_mem_we",    w_mem_we,    m_we);
      chk("w_mem_addr",  w_mem_addr,  8'(8'hFF + m_off));
      chk("w_mem_wdata", w_mem_wdata, m_wdata);
      chk("w_done",      w_done,      m_fin);
      if (mem_we) begin
        log_addr.push_back(mem_addr);
        log_data.push_back(mem_wdata);
      end
      if (w_mem_we) wlog_addr.push_back(w_mem_addr);
      if (done) ndone++;
    end
  end

  task automatic start_load();
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
  endtask

  // Feeds the stream; optional load_start pulse at byte ls_at, reset at byte rst_at
  task automatic drive_stream(input logic [7:0] s[$], input int stall_pct,
                              input int ls_at, input int rst_at);
    int idx = 0;
    int cyc = 0;
    int budget = 4 * s.size() + 200;
    logic took;
    while (idx < s.size() && cyc < budget) begin
      if (rst_at >= 0 && idx == rst_at) begin
        in_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        return;
      end
      in_valid   = ($urandom_range(99) >= stall_pct);
      in_data    = s[idx];
      load_start = (idx == ls_at);
      @(negedge clk);
      took = in_valid && in_ready;
      @(posedge clk); #1;
      load_start = 1'b0;
      if (took) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    chk("stream_complete", idx, s.size());
  endtask

  task automatic run_load(input logic [7:0] s[$], input int stall_pct,
                          input int ls_at, input int rst_at);
    log_addr.delete(); log_data.delete(); wlog_addr.delete(); ndone = 0;
    start_load();
    drive_stream(s, stall_pct, ls_at, rst_at);
    repeat (4) @(posedge clk);
    #1;
  endtask

  logic [7:0] basic[$];
  logic [7:0] bad[$];
  logic [7:0] s[$];

  initial begin
    // XOR of the eight data bytes below is 8'h44
    basic = '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h44};
    bad   = '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00};
    reset = 1'b1; load_start = 1'b0; in_valid = 1'b0; in_data = '0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    chk("rst_mem_addr", mem_addr, 8'h00);
    chk("rst_w_mem_addr", w_mem_addr, 8'hFF);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_busy", busy, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Basic load
    run_load(basic, 0, -1, -1);
    chk("basic_nwrites", log_addr.size(), 2);
    if (log_addr.size() == 2) begin
      chk("basic_addr0", log_addr[0], 8'h00);
      chk("basic_data0", log_data[0], 32'h11223344);
      chk("basic_addr1", log_addr[1], 8'h01);
      chk("basic_data1", log_data[1], 32'hAABBCCDD);
    end
    if (wlog_addr.size() == 2) begin
      chk("wrap_addr0", wlog_addr[0], 8'hFF);
      chk("wrap_addr1", wlog_addr[1], 8'h00);
    end else chk("wrap_nwrites", wlog_addr.size(), 2);
    chk("basic_ndone", ndone, 1);
    chk("basic_chk_err", chk_err, 1'b0);

    // Bad checksum: sticky until next load_start
    run_load(bad, 0, -1, -1);
    chk("bad_nwrites", log_addr.size(), 2);
    chk("bad_chk_err", chk_err, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    chk("bad_chk_err_held", chk_err, 1'b1);
    start_load();
    chk("bad_chk_err_cleared", chk_err, 1'b0);
    drive_stream(basic, 0, -1, -1);
    repeat (4) @(posedge clk);
    #1;

    // Stalls
    run_load(basic, 50, -1, -1);
    chk("stall_nwrites", log_addr.size(), 2);
    if (log_data.size() == 2) begin
      chk("stall_data0", log_data[0], 32'h11223344);
      chk("stall_data1", log_data[1], 32'hAABBCCDD);
    end

    // Reset after count byte + 6 data bytes, then a fresh load
    run_load(basic, 0, -1, 7);
    chk("rstmid_nwrites", log_addr.size(), 1);
    chk("rstmid_busy", busy, 1'b0);
    run_load(basic, 0, -1, -1);
    chk("rstmid_fresh_nwrites", log_addr.size(), 2);
    if (log_data.size() == 2) chk("rstmid_fresh_data1", log_data[1], 32'hAABBCCDD);

    // load_start during DATA is ignored
    run_load(basic, 0, 3, -1);
    chk("busy_start_nwrites", log_addr.size(), 2);
    chk("busy_start_ndone", ndone, 1);

    // Random loads
    for (int it = 0; it < 8; it++) begin
      int n;
      logic [7:0] x;
      n = $urandom_range(5, 1);
      s.delete();
      s.push_back(8'(n));
      x = '0;
      for (int k = 0; k < 4 * n; k++) begin
        s.push_back(8'($urandom));
        x = x ^ s[s.size() - 1];
      end
      s.push_back(($urandom_range(1) == 0) ? x : ~x);
      run_load(s, $urandom_range(60), ($urandom_range(3) == 0) ? 2 : -1, -1);
      chk("rand_nwrites", log_addr.size(), n);
    end

    // Count 0 means 256 words
    s.delete();
    s.push_back(8'h00);
    for (int k = 0; k < 1024; k++) s.push_back(8'(k * 7 + 3));
    s.push_back(8'h00);
    run_load(s, 20, -1, -1);
    chk("n0_nwrites", log_addr.size(), 256);
    if (log_addr.size() == 256) chk("n0_last_addr", log_addr[255], 8'hFF);
    if (wlog_addr.size() == 256) chk("n0_wrap_last_addr", wlog_addr[255], 8'hFE);
    chk("n0_ndone", ndone, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
